main_memory_ctrl: RTL and testbench
===================================

# main_memory_ctrl

Main-memory controller that sits directly downstream of the 2-way L1 cache. It accepts the cache's write-back and fill requests through a valid/ready handshake. Write-backs are absorbed into a small posted write buffer, so an eviction does not stall the following fill. Fills are served either by forwarding from the write buffer or from a 32-entry backing array with a fixed access latency.

## Interface
- ADDR_W, 5, request address width; backing array holds 2^ADDR_W words.
- DATA_W, 3, data word width.
- READ_LAT, 2, array read latency in cycles; legal range ≥1.
- WB_DEPTH, 2, write-buffer entries; legal range ≥1.

- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = write-back (posted), 0 = fill read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write-back data; ignored on reads.
- resp_valid  out  1  one-cycle pulse; resp_data valid.
- resp_data  out  DATA_W  fill data; holds its value until the next response.
- busy  out  1  read in flight (state ≠ IDLE) or write buffer non-empty.
- wb_count  out  clog2(WB_DEPTH+1)  current write-buffer occupancy.

## Operation
- Request handshake:
  - A request transfers at a posedge when req_valid && req_ready.
  - req_ready = (state==IDLE) && (wb_count < WB_DEPTH), registered-state-derived only; it has no combinational path from req_valid, req_we or req_addr.
- Write transfer:
  - {addr, data} is enqueued at the FIFO tail and wb_count increments.
  - Duplicate addresses are enqueued as separate entries; there is no merging.
- Drain:
  - Occurs in any state, in any cycle where wb_count>0 and no write is being enqueued.
  - The head entry is written to the array and dequeued, so wb_count decrements.
  - Drain order is FIFO, so the youngest value for an address ends up in the array.
- Read transfer:
  - All valid buffer entries, including one draining that same cycle, are searched for a match on req_addr.
  - Hit: the youngest matching entry's data is latched and the state goes to RESP.
  - Miss: the state goes to READ_WAIT and the latency counter loads READ_LAT-1.
- FSM:
  - IDLE → RESP on a read transfer that hits the buffer.
  - IDLE → READ_WAIT on a read transfer that misses.
  - IDLE stays IDLE on a write transfer or no transfer.
  - READ_WAIT: the counter decrements each cycle. When the counter is 0, the array word at the latched address is captured into resp_data and the state goes to RESP.
  - RESP: resp_valid=1 for exactly this cycle, then the state goes to IDLE.
- Consistency:
  - A missing read address cannot appear in the buffer while the read is outstanding, because no writes are accepted outside IDLE.
  - Draining during READ_WAIT is therefore safe.
- Array contents:
  - Not affected by reset.
  - Time-zero init: mem[i] = i mod 2^DATA_W.
- Widths:
  - Addresses are compared at the full ADDR_W.
  - The FIFO pointers wrap modulo WB_DEPTH.

## Timing
- Reset values:
  - req_ready=1, resp_valid=0, resp_data=0, busy=0, wb_count=0.
  - state=IDLE, FIFO pointers=0.
- Reset mid-operation: any outstanding read is dropped with no resp_valid, and buffered writes are discarded, never reaching the array.
- Read latency, counting from the acceptance edge:
  - Forward hit: resp_valid is high in the first cycle after acceptance.
  - Miss: resp_valid is high in cycle READ_LAT+1 after acceptance.
  - req_ready returns high in the cycle after the resp_valid cycle, if the buffer is not full.
- Write path:
  - Accepted in 1 cycle with no response pulse.
  - The earliest array update is the edge after the first cycle with no enqueue.
- Back-to-back writes from empty with WB_DEPTH=2:
  - Edges 0 and 1 enqueue, wb_count=2, req_ready=0.
  - Edge 2 drains, wb_count=1, req_ready=1.
- Simultaneous events:
  - A read accepted in a drain cycle still forwards from the draining entry.
  - Enqueue and drain never happen in the same cycle.
- resp_valid is never asserted outside RESP, and never on two consecutive cycles.

## Test plan
- Reset: assert reset for 2 cycles during a READ_WAIT of addr 7 -> no resp_valid, wb_count=0, req_ready=1, busy=0 the cycle after release.
- Read miss, READ_LAT=2: read addr 3 at edge 0 -> resp_valid only in cycle 3, resp_data=3; req_ready low in cycles 1–3.
- Forwarding: write addr 5 data 6 at edge 0, read addr 5 at edge 1 -> resp_valid in cycle 2 with resp_data=6, even though the drain happens at edge 1.
- Youngest wins: write addr 9 data 1, then addr 9 data 4 back-to-back, then read 9 -> resp_data=4. After idling until busy=0, read 9 again -> resp_data=4 from the array.
- Full buffer: three consecutive write requests addr 1/2/4, data 7/6/5 -> third stalls one cycle (req_ready=0 at edge 2). All three then drain in order, and reads return 7/6/5.
- Drain during read: write addr 12 data 2, then immediately read addr 20 (miss) -> resp_data=4 (20 mod 8) after READ_LAT+1 cycles; wb_count reaches 0 during READ_WAIT.

Source files
------------

// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl
//   Main-memory controller downstream of the L1 cache. Write-backs are posted
//   into a small FIFO write buffer and drained into the backing array whenever
//   no write is being enqueued. Fills are forwarded from the buffer
//   (youngest match) or read from the array after READ_LAT cycles.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_we                1 = posted write-back, 0 = fill read
//   req_addr, req_wdata   word address / write-back data
//   resp_valid            one-cycle pulse with fill data in resp_data
//   resp_data             fill data, held until the next response
//   busy                  read outstanding or write buffer non-empty
//   wb_count              write-buffer occupancy
module main_memory_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 3,
    parameter int READ_LAT = 2,
    parameter int WB_DEPTH = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [DATA_W-1:0]               req_wdata,
    output logic                            resp_valid,
    output logic [DATA_W-1:0]               resp_data,
    output logic                            busy,
    output logic [$clog2(WB_DEPTH+1)-1:0]   wb_count
);

    localparam int CNT_W = $clog2(WB_DEPTH + 1);
    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int WORDS = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, READ_WAIT, RESP} state_t;
    typedef logic [WORDS-1:0][DATA_W-1:0] mem_t;

    // Power-up contents mem[i] = i mod 2^DATA_W; reset never touches the array.
    function automatic mem_t mem_init();
        mem_t m;
        for (int unsigned i = 0; i < WORDS; i++) m[i] = DATA_W'(i);
        return m;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (int'(p) == WB_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    mem_t              mem = mem_init();
    logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
    logic [DATA_W-1:0] wb_data [WB_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    state_t            state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] rd_addr;

    logic              wr_xfer, rd_xfer, drain;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  idx;

    assign req_ready  = (state == IDLE) && (32'(count) < WB_DEPTH);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE) || (count != '0);
    assign wb_count   = count;

    assign wr_xfer = req_valid && req_ready && req_we;
    assign rd_xfer = req_valid && req_ready && !req_we;
    assign drain   = !wr_xfer && (count != '0);

    // Walk the buffer oldest to youngest so the last match is the youngest.
    // The head entry is still present in the cycle it drains, so a read
    // accepted then forwards from it.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            if (i < 32'(count) && wb_addr[idx] == req_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[idx];
            end
            idx = ptr_next(idx);
        end
    end

    // Storage without reset: buffer payload and backing array.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (wr_xfer) begin
                wb_addr[tail] <= req_addr;
                wb_data[tail] <= req_wdata;
            end
            if (drain) mem[wb_addr[head]] <= wb_data[head];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            lat_cnt   <= '0;
            rd_addr   <= '0;
            resp_data <= '0;
        end else begin
            if (wr_xfer) begin
                tail  <= ptr_next(tail);
                count <= count + 1'b1;
            end else if (drain) begin
                head  <= ptr_next(head);
                count <= count - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rd_xfer) begin
                        if (fwd_hit) begin
                            resp_data <= fwd_data;
                            state     <= RESP;
                        end else begin
                            rd_addr <= req_addr;
                            lat_cnt <= LAT_W'(READ_LAT - 1);
                            state   <= READ_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (lat_cnt == '0) begin
                        resp_data <= mem[rd_addr];
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// tb_main_memory_ctrl
//   Drives main_memory_ctrl with directed scenarios followed by random traffic
//   and compares every output each cycle against a transaction-level model:
//   a queue of posted writes, an array image, and one outstanding read with a
//   known response age.
module tb_main_memory_ctrl;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 3;
    localparam int READ_LAT = 2;
    localparam int WB_DEPTH = 2;
    localparam int CNT_W    = $clog2(WB_DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              busy;
    logic [CNT_W-1:0]  wb_count;

    main_memory_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT),
        .WB_DEPTH (WB_DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy),
        .wb_count   (wb_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    // Reference model state
    wr_t q[$];
    int  mm [2**ADDR_W];
    bit  rd_out;
    int  rd_age, rd_lat, rd_val;
    int  last_resp;

    int  n_vec = 0;
    int  n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return !rd_out && (q.size() < WB_DEPTH);
    endfunction

    // One clock cycle: check outputs against the model, drive inputs, advance.
    task automatic cycle(input bit v, input bit we, input int a, input int d, input bit rst);
        bit resp_now, rdy, hit;
        int val;
        rdy      = model_ready();
        resp_now = rd_out && (rd_age == rd_lat);
        check("req_ready", int'(req_ready), int'(rdy));
        check("resp_valid", int'(resp_valid), int'(resp_now));
        check("resp_data", int'(resp_data), resp_now ? rd_val : last_resp);
        check("busy", int'(busy), int'(rd_out || q.size() > 0));
        check("wb_count", int'(wb_count), q.size());

        reset     = rst;
        req_valid = v;
        req_we    = we;
        req_addr  = ADDR_W'(a);
        req_wdata = DATA_W'(d);
        @(posedge clock);

        if (rst) begin
            q.delete();
            rd_out    = 1'b0;
            last_resp = 0;
        end else begin
            if (rd_out) begin
                if (rd_age == rd_lat) begin
                    rd_out    = 1'b0;
                    last_resp = rd_val;
                end else begin
                    rd_age++;
                end
            end
            if (v && rdy && !we) begin
                hit = 1'b0;
                val = mm[a % (2**ADDR_W)];
                foreach (q[i]) if (q[i].addr == a % (2**ADDR_W)) begin
                    hit = 1'b1;
                    val = q[i].data;
                end
                rd_out = 1'b1;
                rd_age = 1;
                rd_lat = hit ? 1 : READ_LAT + 1;
                rd_val = val;
            end
            if (v && rdy && we) begin
                q.push_back('{a % (2**ADDR_W), d % (2**DATA_W)});
            end else if (q.size() > 0) begin
                mm[q[0].addr] = q[0].data;
                void'(q.pop_front());
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0);
    endtask

    // Hold a request until the model says it is accepted (bounded).
    task automatic req(input bit we, input int a, input int d);
        bit rdy;
        for (int k = 0; k < 20; k++) begin
            rdy = model_ready();
            cycle(1, we, a, d, 0);
            if (rdy) return;
        end
        check("req_accept_timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) mm[i] = i % (2**DATA_W);
        rd_out    = 1'b0;
        rd_age    = 0;
        rd_lat    = 0;
        rd_val    = 0;
        last_resp = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        @(posedge clock);
        @(negedge clock);
        cycle(0, 0, 0, 0, 1);

        // Read miss to the initial array image
        req(0, 3, 0);
        idle(4);
        // Forward from an entry draining in the same cycle
        req(1, 5, 6);
        req(0, 5, 0);
        idle(3);
        // Youngest duplicate wins, then the same value comes back from the array
        req(1, 9, 1);
        req(1, 9, 4);
        req(0, 9, 0);
        idle(8);
        req(0, 9, 0);
        idle(4);
        // Full buffer stall, then ordered drain
        req(1, 1, 7);
        req(1, 2, 6);
        req(1, 4, 5);
        idle(4);
        req(0, 1, 0); idle(4);
        req(0, 2, 0); idle(4);
        req(0, 4, 0); idle(4);
        // Drain during a read miss
        req(1, 12, 2);
        req(0, 20, 0);
        idle(5);
        // Reset during READ_WAIT drops the read
        req(0, 7, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        idle(4);
        // Reset with buffered writes discards them
        req(1, 6, 1);
        req(1, 6, 2);
        cycle(0, 0, 0, 0, 1);
        idle(2);
        req(0, 6, 0);
        idle(4);

        // Random traffic, biased toward a few addresses to produce hits
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                cycle(0, 0, 0, 0, 1);
            end else begin
                cycle($urandom_range(0, 9) < 6,
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3))
                                                  : int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 7)),
                      0);
            end
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
